// File: rtl/mips_mult_div_pkg.sv
// mips_mult_div_pkg -- shared types and constants for the HI/LO multiply/divide unit.
//   mdOpT          : Op encoding (MULT, MULTU, DIV, DIVU)
//   mdStateT       : unit FSM states
//   ITERATIONS     : iterative step count per operation
//   DIV0_QUOTIENT  : LO value returned for a divide by zero
//   magnitude()    : absolute value of a signed operand, passthrough for unsigned
package mips_mult_div_pkg;

   typedef enum logic [1:0] {
      OpMult  = 2'd0,
      OpMultu = 2'd1,
      OpDiv   = 2'd2,
      OpDivu  = 2'd3
   } mdOpT;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } mdStateT;

   localparam int unsigned ITERATIONS    = 32;
   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   // 0x80000000 maps to itself, which is its correct unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
      return (isSigned && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/mips_mult_div_if.sv
// mips_mult_div_if -- request/result bundle between the pipeline and the HI/LO unit.
//   master : drives Start, Op, OperandA, OperandB, HiWrite, LoWrite, DataIn
//            and observes Busy, Done, Hi, Lo
//   slave  : the multiply/divide unit itself
interface mips_mult_div_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  Start;
   logic [1:0]            Op;
   logic [DATA_WIDTH-1:0] OperandA;
   logic [DATA_WIDTH-1:0] OperandB;
   logic                  HiWrite;
   logic                  LoWrite;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  Busy;
   logic                  Done;
   logic [DATA_WIDTH-1:0] Hi;
   logic [DATA_WIDTH-1:0] Lo;

   modport master (
      output Start, Op, OperandA, OperandB, HiWrite, LoWrite, DataIn,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, DataIn,
      output Busy, Done, Hi, Lo
   );
endinterface

// File: rtl/mips_mult_div.sv
// mips_mult_div -- MIPS HI/LO multiply/divide unit.
//   Iterative shift-add multiply and restoring divide on operand magnitudes,
//   32 RUN cycles per operation, with sign fix-up on the final write to HI/LO.
//   Divide by zero completes immediately with LO=all-ones, HI=dividend.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : mips_mult_div_if.slave (Start/Op/operands/MTHI/MTLO in, Busy/Done/Hi/Lo out)
// Build option:
//   MIPS_MULT_DIV_FAST_MULT_EN : MULT/MULTU finish in one cycle (IDLE->DONE).
module mips_mult_div
   import mips_mult_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic           CLK,
   input  logic           RST_N,
   mips_mult_div_if.slave bus
);

   localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);

   mdStateT               stateQ, stateD;
   logic [4:0]            countQ, countD;
   logic [DATA_WIDTH-1:0] workHiQ, workLoQ, operandQ, hiQ, loQ;
   logic                  isDivQ, negResQ, negRemQ;

   mdOpT                  opIn;
   logic                  inSigned, inDiv, div0, skipRun, accept, lastStep;
   logic                  negResIn, negRemIn;
   logic [DATA_WIDTH-1:0] magA, magB;

   logic [DATA_WIDTH:0]   mulSum, divShift;
   logic                  divFits;
   logic [DATA_WIDTH-1:0] divDiff, stepHi, stepLo, resHi, resLo;
   logic [63:0]           product;

   // Request decode (only meaningful in IDLE, where Start is accepted)
   always_comb begin
      opIn     = mdOpT'(bus.Op);
      inDiv    = bus.Op[1];
      inSigned = ~bus.Op[0];
      magA     = magnitude(bus.OperandA, inSigned);
      magB     = magnitude(bus.OperandB, inSigned);
      negResIn = inSigned & (bus.OperandA[31] ^ bus.OperandB[31]);
      negRemIn = (opIn == OpDiv) & bus.OperandA[31];
      div0     = inDiv & (bus.OperandB == '0);
      accept   = (stateQ == StIdle) & bus.Start;
      lastStep = (stateQ == StRun) & (countQ == LAST_COUNT);
   end

`ifdef MIPS_MULT_DIV_FAST_MULT_EN
   logic [63:0] fastMag, fastProd;
   always_comb begin
      fastMag  = {32'd0, magA} * {32'd0, magB};
      fastProd = negResIn ? -fastMag : fastMag;
      skipRun  = div0 | ~inDiv;
   end
`else
   always_comb skipRun = div0;
`endif

   // One iteration step. workHi/workLo hold the partial product for multiply,
   // and remainder/shifting-dividend-into-quotient for divide.
   always_comb begin
      mulSum   = {1'b0, workHiQ} + (workLoQ[0] ? {1'b0, operandQ} : '0);
      divShift = {workHiQ, workLoQ[31]};
      divFits  = divShift >= {1'b0, operandQ};
      // Only used when divFits, so the result is below the divisor and fits.
      divDiff  = divShift[DATA_WIDTH-1:0] - operandQ;
      if (isDivQ) begin
         stepHi = divFits ? divDiff : divShift[DATA_WIDTH-1:0];
         stepLo = {workLoQ[30:0], divFits};
      end else begin
         stepHi = mulSum[DATA_WIDTH:1];
         stepLo = {mulSum[0], workLoQ[31:1]};
      end
      product = negResQ ? -{stepHi, stepLo} : {stepHi, stepLo};
      if (isDivQ) begin
         resLo = negResQ ? -stepLo : stepLo;
         resHi = negRemQ ? -stepHi : stepHi;
      end else begin
         resLo = product[31:0];
         resHi = product[63:32];
      end
   end

   // FSM next state
   always_comb begin
      stateD = stateQ;
      countD = countQ;
      case (stateQ)
         StIdle: begin
            if (bus.Start) begin
               countD = '0;
               stateD = skipRun ? StDone : StRun;
            end
         end
         StRun: begin
            countD = countQ + 5'd1;
            if (countQ == LAST_COUNT) stateD = StDone;
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stateQ <= StIdle;
         countQ <= '0;
      end else begin
         stateQ <= stateD;
         countQ <= countD;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         workHiQ  <= '0;
         workLoQ  <= '0;
         operandQ <= '0;
         isDivQ   <= 1'b0;
         negResQ  <= 1'b0;
         negRemQ  <= 1'b0;
         hiQ      <= '0;
         loQ      <= '0;
      end else begin
         if (accept) begin
            workHiQ  <= '0;
            workLoQ  <= magA;
            operandQ <= magB;
            isDivQ   <= inDiv;
            negResQ  <= negResIn;
            negRemQ  <= negRemIn;
         end else if (stateQ == StRun) begin
            workHiQ <= stepHi;
            workLoQ <= stepLo;
         end

         // MTHI/MTLO first so a same-cycle immediate result overrides them.
         if (stateQ == StIdle && bus.HiWrite) hiQ <= bus.DataIn;
         if (stateQ == StIdle && bus.LoWrite) loQ <= bus.DataIn;

         if (accept && div0) begin
            hiQ <= bus.OperandA;
            loQ <= DIV0_QUOTIENT;
`ifdef MIPS_MULT_DIV_FAST_MULT_EN
         end else if (accept && !inDiv) begin
            hiQ <= fastProd[63:32];
            loQ <= fastProd[31:0];
`endif
         end else if (lastStep) begin
            hiQ <= resHi;
            loQ <= resLo;
         end
      end
   end

   assign bus.Busy = (stateQ != StIdle);
   assign bus.Done = (stateQ == StDone);
   assign bus.Hi   = hiQ;
   assign bus.Lo   = loQ;

endmodule

// File: tb/tb_mips_mult_div.sv
// tb_mips_mult_div -- directed self-checking bench for mips_mult_div.
//   Hand-computed HI/LO and Start-to-Done latencies for multiply, divide,
//   divide by zero, ignored requests while busy, MTHI/MTLO and reset abort.
//   Latency expectations follow MIPS_MULT_DIV_FAST_MULT_EN when defined.
module tb_mips_mult_div;
   import mips_mult_div_pkg::*;

`ifdef MIPS_MULT_DIV_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic CLK = 1'b0;
   logic RST_N;
   int   errCount   = 0;
   int   checkCount = 0;

   mips_mult_div_if bus ();

   mips_mult_div dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; launches one op and follows it to Done.
   // mthi: assert HiWrite (DataIn=0x55) together with Start.
   // injectAt: cycle at which Start+HiWrite(0xAAAA) is re-asserted (0 = never).
   task automatic doOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input int expLat, input bit mthi, input int injectAt);
      int          n;
      bit          seen;
      logic [31:0] hiBefore;
      hiBefore     = bus.Hi;
      bus.Op       = op;
      bus.OperandA = a;
      bus.OperandB = b;
      bus.Start    = 1'b1;
      bus.HiWrite  = mthi;
      bus.DataIn   = 32'h55;
      n            = 0;
      seen         = 1'b0;
      while (!seen && n < 40) begin
         @(negedge CLK);
         n++;
         if (bus.Done) seen = 1'b1;
         if (n == 1) begin
            bus.Start    = 1'b0;
            bus.HiWrite  = 1'b0;
            bus.OperandA = ~a;
            bus.OperandB = ~b;
            bus.Op       = ~op;
            if (expLat > 1) begin
               checkVal({tag, " busy"}, 32'(bus.Busy), 32'd1);
               if (!mthi) checkVal({tag, " hi held"}, bus.Hi, hiBefore);
            end
         end
         if (injectAt != 0 && n == injectAt) begin
            bus.Start   = 1'b1;
            bus.HiWrite = 1'b1;
            bus.DataIn  = 32'hAAAA;
            bus.Op      = 2'(OpDivu);
         end else if (injectAt != 0 && n == injectAt + 1) begin
            bus.Start   = 1'b0;
            bus.HiWrite = 1'b0;
         end
      end
      bus.Start   = 1'b0;
      bus.HiWrite = 1'b0;
      checkVal({tag, " latency"}, 32'(n), 32'(expLat));
      checkVal({tag, " hi"}, bus.Hi, expHi);
      checkVal({tag, " lo"}, bus.Lo, expLo);
      @(negedge CLK);
      checkVal({tag, " done pulse"}, 32'(bus.Done), 32'd0);
      checkVal({tag, " idle"}, 32'(bus.Busy), 32'd0);
   endtask

   initial begin
      int doneCount;
      RST_N        = 1'b0;
      bus.Start    = 1'b0;
      bus.Op       = 2'd0;
      bus.OperandA = '0;
      bus.OperandB = '0;
      bus.HiWrite  = 1'b0;
      bus.LoWrite  = 1'b0;
      bus.DataIn   = '0;
      repeat (2) @(negedge CLK);
      checkVal("reset busy", 32'(bus.Busy), 32'd0);
      checkVal("reset done", 32'(bus.Done), 32'd0);
      checkVal("reset hi", bus.Hi, 32'd0);
      checkVal("reset lo", bus.Lo, 32'd0);
      RST_N = 1'b1;

      // MTHI / MTLO in IDLE
      bus.HiWrite = 1'b1;
      bus.DataIn  = 32'h1234;
      @(negedge CLK);
      bus.HiWrite = 1'b0;
      bus.LoWrite = 1'b1;
      bus.DataIn  = 32'h5678;
      @(negedge CLK);
      bus.LoWrite = 1'b0;
      checkVal("mthi", bus.Hi, 32'h1234);
      checkVal("mtlo", bus.Lo, 32'h5678);

      doOp("multu max", 2'(OpMultu), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 1'b0, 0);
      doOp("mult -3*7", 2'(OpMult), 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 1'b0, 0);
      doOp("div -7/2", 2'(OpDiv), 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, 0);
      doOp("div 7/-2", 2'(OpDiv), 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, 33, 1'b0, 0);
      doOp("divu 100/7", 2'(OpDivu), 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 0);

      // Reset in the middle of a DIVU: immediate clear, no Done afterwards
      doneCount    = 0;
      bus.Op       = 2'(OpDivu);
      bus.OperandA = 32'd1000;
      bus.OperandB = 32'd3;
      bus.Start    = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(negedge CLK);
         bus.Start = 1'b0;
         if (bus.Done) doneCount++;
      end
      RST_N = 1'b0;
      #1;
      checkVal("abort busy", 32'(bus.Busy), 32'd0);
      checkVal("abort hi", bus.Hi, 32'd0);
      checkVal("abort lo", bus.Lo, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         if (bus.Done) doneCount++;
      end
      checkVal("abort no done", 32'(doneCount), 32'd0);
      checkVal("abort lo stays", bus.Lo, 32'd0);

      // First Start on the first edge after reset release
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      doOp("divu 5/0", 2'(OpDivu), 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b0, 0);
      doOp("div min/-1", 2'(OpDiv), 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 33, 1'b0, 0);
      doOp("div 9/0", 2'(OpDiv), 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1, 1'b0, 0);

      // Start + MTHI together in IDLE: result overwrites HI
      doOp("divu 9/2 mthi", 2'(OpDivu), 32'd9, 32'd2, 32'd1, 32'd4, 33, 1'b1, 0);

      // Start + HiWrite while busy are both ignored
`ifdef MIPS_MULT_DIV_FAST_MULT_EN
      doOp("busy ignore", 2'(OpDivu), 32'd12, 32'd1, 32'd0, 32'd12, 33, 1'b0, 10);
`else
      doOp("busy ignore", 2'(OpMultu), 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0, 10);
`endif
      doneCount = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         if (bus.Done || bus.Busy) doneCount++;
      end
      checkVal("busy ignore no queue", 32'(doneCount), 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
